seg_scan_rx: RTL and testbench

Receiver for the multiplexed seven-segment scan bus driven by our display blocks. It samples the `anodes`/`cathodes` pair, waits for each digit slot to settle, and rebuilds a full 8-digit frame in registers. It then reports the frame to its consumer with a one-cycle strobe. It sits in loopback benches and on-chip monitors, in the same clock domain as the display driver, so no synchronisers are needed.

---
 rtl/seg_pkg.sv | 46 ++++
 rtl/seg_hex_decode.sv | 25 ++
 rtl/seg_scan_rx.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scan bus.
//   - segment bit indices (bit0 = a ... bit6 = g, bit7 = dp)
//   - active-high hex glyphs 0-9, A, b, C, d, E, F (shared with transmit-side encoders)
//   - receiver FSM state enum
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef enum logic {
        ST_SETTLE   = 1'b0,
        ST_CAPTURED = 1'b1
    } scan_state_e;

    // Active-high segment pattern (g..a) for a hex nibble.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            4'hF:    pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational active-high segment pattern -> {valid, nibble}.
// The decimal point is ignored; unknown patterns give valid=0, nibble=0.
// Ports:
//   seg     in  8  active-high segments (bit0 = a ... bit7 = dp)
//   valid   out 1  pattern is one of the 16 hex glyphs
//   nibble  out 4  decoded value (0 when not valid)
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [7:0] seg,
    output logic       valid,
    output logic [3:0] nibble
);

    // Glyphs are unique, so OR-ing all matches selects at most one value.
    always_comb begin
        valid  = 1'b0;
        nibble = 4'h0;
        for (int k = 0; k < 16; k++) begin
            valid  = valid | (seg[SEG_G:SEG_A] == hex_seg(4'(k)));
            nibble = nibble | ((seg[SEG_G:SEG_A] == hex_seg(4'(k))) ? 4'(k) : 4'h0);
        end
    end

endmodule

// File: rtl/seg_scan_rx.sv
// seg_scan_rx: receiver for the multiplexed seven-segment scan bus.
// Samples {anodes, cathodes}, waits for each digit slot to be stable for
// STABLE_CYCLES samples, rebuilds a DIGITS-wide frame and strobes it out.
// Optional feature macro: SEG_HEX_DECODE_EN adds frame_hex / hex_valid.
// Ports:
//   clk          in   1          system clock, rising edge
//   rst          in   1          synchronous active-high reset
//   anodes       in   DIGITS     digit enables, active-low
//   cathodes     in   8          segments, active-low (bit0 = a ... bit7 = dp)
//   frame_seg    out  DIGITS*8   captured frame, active-high, digit i at [8i+7:8i]
//   frame_valid  out  1          one-cycle strobe when frame_seg updates
//   err_multi    out  1          pulse: stable sample with more than one anode low
//   lost         out  1          level: no capture within TIMEOUT_CYCLES
//   frame_hex    out  DIGITS*4   decoded digits        (SEG_HEX_DECODE_EN only)
//   hex_valid    out  DIGITS     per-digit decode flag (SEG_HEX_DECODE_EN only)
// Parameters: STABLE_CYCLES >= 2, TIMEOUT_CYCLES >= 2, DIGITS >= 2.
module seg_scan_rx
    import seg_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     anodes,
    input  logic [7:0]            cathodes,
    output logic [DIGITS*8-1:0]   frame_seg,
    output logic                  frame_valid,
    output logic                  err_multi,
    output logic                  lost
`ifdef SEG_HEX_DECODE_EN
    ,
    output logic [DIGITS*4-1:0]   frame_hex,
    output logic [DIGITS-1:0]     hex_valid
`endif
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int IW = $clog2(DIGITS);
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    logic [DIGITS+7:0]   sample_r;
    logic [SW-1:0]       stab_cnt_r;
    scan_state_e         state_r;
    logic [DIGITS*8-1:0] frame_buf_r;
    logic [DIGITS-1:0]   seen_r;
    logic [TW-1:0]       to_cnt_r;

    logic [CW-1:0]       low_cnt_s;
    logic [IW-1:0]       digit_idx_s;
    logic                change_s;
    logic                eval_s;
    logic                cap_s;
    logic                multi_s;
    logic                full_s;
    logic                to_max_s;

    // Count low anodes in the held sample and locate the selected digit.
    always_comb begin
        low_cnt_s   = {CW{1'b0}};
        digit_idx_s = {IW{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            low_cnt_s   = low_cnt_s + {{(CW-1){1'b0}}, ~sample_r[8+i]};
            digit_idx_s = sample_r[8+i] ? digit_idx_s : IW'(i);
        end
    end

    assign change_s = ({anodes, cathodes} != sample_r);
    // The held sample has been identical for STABLE_CYCLES presentations.
    assign eval_s   = (state_r == ST_SETTLE) && (stab_cnt_r == STAB_MAX);
    assign cap_s    = eval_s && (low_cnt_s == CW'(1));
    assign multi_s  = eval_s && (low_cnt_s > CW'(1));
    assign full_s   = (seen_r == {DIGITS{1'b1}});
    assign to_max_s = (to_cnt_r == TO_MAX);

    // Scan FSM, digit buffer, frame assembly and link timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            // All-ones matches an idle bus, so a blank start needs no extra settle.
            sample_r    <= {(DIGITS+8){1'b1}};
            stab_cnt_r  <= {SW{1'b0}};
            state_r     <= ST_SETTLE;
            frame_buf_r <= {(DIGITS*8){1'b0}};
            seen_r      <= {DIGITS{1'b0}};
            to_cnt_r    <= {TW{1'b0}};
            frame_seg   <= {(DIGITS*8){1'b0}};
            frame_valid <= 1'b0;
            err_multi   <= 1'b0;
            lost        <= 1'b1;
        end else begin
            sample_r <= {anodes, cathodes};

            if (change_s) begin
                stab_cnt_r <= {SW{1'b0}};
            end else if (stab_cnt_r != STAB_MAX) begin
                stab_cnt_r <= stab_cnt_r + 1'b1;
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end

            // A change arriving in the evaluation cycle restarts settling at once,
            // so the new value still gets its own evaluation.
            case (state_r)
                ST_SETTLE:   state_r <= (eval_s && !change_s) ? ST_CAPTURED : ST_SETTLE;
                ST_CAPTURED: state_r <= change_s ? ST_SETTLE : ST_CAPTURED;
                default:     state_r <= ST_SETTLE;
            endcase

            err_multi <= multi_s;

            if (cap_s) begin
                frame_buf_r[8*digit_idx_s +: 8] <= ~sample_r[7:0];
            end

            // Completion and timeout both discard seen; a capture in the timeout
            // cycle takes precedence, so a completing digit is never lost.
            if (full_s) begin
                frame_seg   <= frame_buf_r;
                frame_valid <= 1'b1;
                seen_r      <= {DIGITS{1'b0}};
            end else if (cap_s) begin
                frame_valid         <= 1'b0;
                seen_r[digit_idx_s] <= 1'b1;
            end else if (to_max_s) begin
                frame_valid <= 1'b0;
                seen_r      <= {DIGITS{1'b0}};
            end else begin
                frame_valid <= 1'b0;
            end

            if (cap_s) begin
                to_cnt_r <= {TW{1'b0}};
                lost     <= 1'b0;
            end else if (to_max_s) begin
                lost     <= 1'b1;
            end else begin
                to_cnt_r <= to_cnt_r + 1'b1;
            end
        end
    end

`ifdef SEG_HEX_DECODE_EN
    logic [DIGITS-1:0]   dec_valid_s;
    logic [DIGITS*4-1:0] dec_nib_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg_hex_decode u_dec (
            .seg    (frame_buf_r[8*g +: 8]),
            .valid  (dec_valid_s[g]),
            .nibble (dec_nib_s[4*g +: 4])
        );
    end

    // Decoded view updates on the same edge as frame_seg.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_hex <= {(DIGITS*4){1'b0}};
            hex_valid <= {DIGITS{1'b0}};
        end else if (full_s) begin
            frame_hex <= dec_nib_s;
            hex_valid <= dec_valid_s;
        end else begin
            frame_hex <= frame_hex;
            hex_valid <= hex_valid;
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_rx.sv
// tb_seg_scan_rx: randomized and directed stimulus for seg_scan_rx, checked
// every cycle against a run-length reference model of the scan bus.
module tb_seg_scan_rx;

    localparam int ST = 4;
    localparam int TO = 300;
    localparam logic [63:0] F_0123 = 64'h077D6D664F5B063F;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  anodes;
    logic [7:0]  cathodes;
    logic [63:0] frame_seg;
    logic        frame_valid;
    logic        err_multi;
    logic        lost;
`ifdef SEG_HEX_DECODE_EN
    logic [31:0] frame_hex;
    logic [7:0]  hex_valid;
`endif

    seg_scan_rx #(.DIGITS(8), .STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .anodes      (anodes),
        .cathodes    (cathodes),
        .frame_seg   (frame_seg),
        .frame_valid (frame_valid),
        .err_multi   (err_multi),
        .lost        (lost)
`ifdef SEG_HEX_DECODE_EN
        ,
        .frame_hex   (frame_hex),
        .hex_valid   (hex_valid)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int fv_cnt     = 0;
    int err_cnt    = 0;
    bit chk_en     = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Hex glyph lookup: returns {valid, nibble}.
    function automatic logic [4:0] hex_of(input logic [7:0] p);
        logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        logic [4:0] r = 5'h00;
        for (int k = 0; k < 16; k++) begin
            if (p[6:0] == tbl[k]) r = {1'b1, 4'(k)};
        end
        return r;
    endfunction

    // ---------------- reference model ----------------
    logic [15:0] m_last;
    int          m_run;
    bit          m_pend, m_cpend;
    logic [15:0] m_pval;
    logic [7:0]  m_buf [8];
    logic [7:0]  m_seen;
    int          m_idle;
    logic [63:0] e_seg;
    logic        e_fv, e_err, e_lost;
    logic [31:0] e_hex;
    logic [7:0]  e_hv;

    task automatic model_step();
        bit capd = 1'b0;
        int nlow = 0;
        int idx  = 0;
        if (rst) begin
            m_last = 16'hFFFF; m_run = 1; m_pend = 0; m_cpend = 0;
            m_seen = 8'h00; m_idle = 0;
            for (int i = 0; i < 8; i++) m_buf[i] = 8'h00;
            e_seg = 64'h0; e_fv = 0; e_err = 0; e_lost = 1; e_hex = 32'h0; e_hv = 8'h00;
        end else begin
            e_fv = 0; e_err = 0;
            if (m_cpend) begin
                for (int i = 0; i < 8; i++) begin
                    logic [4:0] h = hex_of(m_buf[i]);
                    e_seg[8*i +: 8] = m_buf[i];
                    e_hex[4*i +: 4] = h[3:0];
                    e_hv[i]         = h[4];
                end
                e_fv = 1; m_seen = 8'h00; m_cpend = 0;
            end
            if (m_pend) begin
                for (int i = 0; i < 8; i++) begin
                    if (!m_pval[8+i]) begin nlow++; idx = i; end
                end
                if (nlow == 1) begin
                    m_buf[idx]  = ~m_pval[7:0];
                    m_seen[idx] = 1'b1;
                    capd = 1'b1;
                    if (m_seen == 8'hFF) m_cpend = 1;
                end else if (nlow > 1) begin
                    e_err = 1;
                end
                m_pend = 0;
            end
            if (capd) begin
                m_idle = 0; e_lost = 0;
            end else if (m_idle == TO - 1) begin
                e_lost = 1; m_seen = 8'h00;
            end else begin
                m_idle++;
            end
            // A value held for ST consecutive samples is evaluated one edge later.
            if ({anodes, cathodes} == m_last) begin
                if (m_run <= ST) m_run++;
            end else begin
                m_last = {anodes, cathodes}; m_run = 1;
            end
            if (m_run == ST) begin m_pend = 1; m_pval = m_last; end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle output comparison on the falling edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("frame_valid", {63'h0, frame_valid}, {63'h0, e_fv});
            check("err_multi", {63'h0, err_multi}, {63'h0, e_err});
            check("lost", {63'h0, lost}, {63'h0, e_lost});
            check("frame_seg", frame_seg, e_seg);
`ifdef SEG_HEX_DECODE_EN
            check("frame_hex", {32'h0, frame_hex}, {32'h0, e_hex});
            check("hex_valid", {56'h0, hex_valid}, {56'h0, e_hv});
`endif
            if (frame_valid) fv_cnt++;
            if (err_multi) err_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic [7:0] a, input logic [7:0] c, input int n);
        anodes = a; cathodes = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [63:0] segs, input int lo, input int hi, input int len);
        for (int i = lo; i <= hi; i++) hold(~(8'h01 << i), ~segs[8*i +: 8], len);
    endtask

    int f0, e0;
    logic [63:0] rnd_frame;

    initial begin
        rst = 1'b1; anodes = 8'hFF; cathodes = 8'hFF;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_seg", frame_seg, 64'h0);
        check("rst_lost", {63'h0, lost}, 64'h1);
        check("rst_fv", {63'h0, frame_valid}, 64'h0);
        rst = 1'b0;
        hold(8'hFF, 8'hFF, 5);

        // Ordered scan "01234567".
        f0 = fv_cnt;
        scan(F_0123, 0, 7, 10);
        hold(8'hFF, 8'hFF, 5);
        check("scan_frames", 64'(fv_cnt - f0), 64'd1);
        check("scan_dig0", {56'h0, frame_seg[7:0]}, 64'h3F);
        check("scan_dig1", {56'h0, frame_seg[15:8]}, 64'h06);
        check("scan_lost", {63'h0, lost}, 64'h0);
`ifdef SEG_HEX_DECODE_EN
        check("scan_hex", {32'h0, frame_hex}, 64'h76543210);
`endif

        // Short glitch on slot 3 is not captured.
        f0 = fv_cnt;
        scan(F_0123, 0, 2, 10);
        hold(8'hF7, ~F_0123[31:24], 5);
        hold(8'hF7, 8'h00, 3);
        hold(8'hF7, ~F_0123[31:24], 10);
        scan(F_0123, 4, 7, 10);
        hold(8'hFF, 8'hFF, 5);
        check("glitch_frames", 64'(fv_cnt - f0), 64'd1);
        check("glitch_seg", frame_seg, F_0123);

        // Two anodes low mid-frame: one error, partial frame kept.
        f0 = fv_cnt; e0 = err_cnt;
        scan(F_0123, 0, 3, 10);
        hold(8'b1111_0011, 8'hC0, 8);
        scan(F_0123, 4, 7, 10);
        hold(8'hFF, 8'hFF, 5);
        check("multi_err", 64'(err_cnt - e0), 64'd1);
        check("multi_frames", 64'(fv_cnt - f0), 64'd1);

        // Partial frame then timeout; recovery on next scan.
        f0 = fv_cnt;
        scan(F_0123, 0, 4, 10);
        hold(8'hFF, 8'hFF, TO + 50);
        check("to_lost", {63'h0, lost}, 64'h1);
        check("to_frames", 64'(fv_cnt - f0), 64'd0);
        scan(F_0123, 0, 0, 10);
        check("to_recover", {63'h0, lost}, 64'h0);
        scan(F_0123, 1, 7, 10);
        hold(8'hFF, 8'hFF, 5);
        check("to_frames2", 64'(fv_cnt - f0), 64'd1);

        // Reset after six digits discards the partial frame.
        scan(F_0123, 0, 5, 10);
        rst = 1'b1;
        hold(8'hFF, 8'hFF, 2);
        check("mid_rst_seg", frame_seg, 64'h0);
        check("mid_rst_lost", {63'h0, lost}, 64'h1);
        rst = 1'b0;
        f0 = fv_cnt;
        scan(F_0123, 6, 7, 10);
        hold(8'hFF, 8'hFF, 10);
        check("mid_rst_frames", 64'(fv_cnt - f0), 64'd0);

        // Non-hex pattern 0x49 on digit 2.
        scan(64'h071F0F6F3F49063F, 0, 7, 8);
        hold(8'hFF, 8'hFF, 5);
        check("bad_dig2", {56'h0, frame_seg[23:16]}, 64'h49);
`ifdef SEG_HEX_DECODE_EN
        check("bad_hv2", {63'h0, hex_valid[2]}, 64'h0);
        check("bad_nib2", {60'h0, frame_hex[11:8]}, 64'h0);
`endif

        // Random frames and random bus noise, including boundary hold lengths.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                rnd_frame = {$urandom, $urandom};
                for (int d = 0; d < 8; d++) scan(rnd_frame, d, d, $urandom_range(ST - 1, ST + 5));
            end else begin
                for (int j = 0; j < 12; j++) begin
                    case ($urandom_range(0, 3))
                        0:       hold(8'hFF, 8'($urandom), $urandom_range(1, 6));
                        1:       hold(~((8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7))),
                                      8'($urandom), $urandom_range(1, 6));
                        default: hold(~(8'h01 << $urandom_range(0, 7)), 8'($urandom), $urandom_range(1, 6));
                    endcase
                end
            end
        end
        hold(8'hFF, 8'hFF, 10);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
